tlb_write_ctrl: RTL and testbench

//  Write-side counterpart of the TLBRD capture path: executes TLBWR/TLBFILL by packing
//  CSR.TLBEHI/TLBELO0/TLBELO1/TLBIDX/ASID into a TLB entry and writing it to the TLB array

---
 rtl/tlb_write_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_tlb_write_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_write_ctrl.sv
// tlb_write_ctrl
// Executes TLBWR / TLBFILL: captures the CSR view of a TLB entry at command
// accept, presents it to the TLB array over a valid/ready write port, and
// pulses done once the array has taken it. TLBFILL targets come from an
// internal round-robin fill pointer; TLBWR targets come from TLBIDX.Index.

module tlb_write_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             rst_n,

    // command side (commit-stage TLB instruction issue)
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_is_fill,
    input  logic [31:0]      csr_tlbehi,
    input  logic [31:0]      csr_tlbelo0,
    input  logic [31:0]      csr_tlbelo1,
    input  logic [31:0]      csr_tlbidx,
    input  logic [9:0]       csr_asid,
    input  logic [5:0]       csr_ecode,

    // TLB array write port
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [IDX_W-1:0] wr_index,
    output logic             wr_e,
    output logic [18:0]      wr_vppn,
    output logic [5:0]       wr_ps,
    output logic             wr_g,
    output logic [9:0]       wr_asid,
    output logic [19:0]      wr_ppn0,
    output logic [19:0]      wr_ppn1,
    output logic [5:0]       wr_flags0,
    output logic [5:0]       wr_flags1,

    output logic             done
);

    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] fill_ptr_q, fill_ptr_d;
    logic             is_fill_q, is_fill_d;

    // captured entry; these registers are the wr_* outputs themselves
    logic [IDX_W-1:0] index_q, index_d;
    logic             e_q, e_d;
    logic [18:0]      vppn_q, vppn_d;
    logic [5:0]       ps_q, ps_d;
    logic             g_q, g_d;
    logic [9:0]       asid_q, asid_d;
    logic [19:0]      ppn0_q, ppn0_d;
    logic [19:0]      ppn1_q, ppn1_d;
    logic [5:0]       flags0_q, flags0_d;
    logic [5:0]       flags1_q, flags1_d;

    logic cmd_accept;
    logic wr_fire;

    // CSR fields that have no place in a TLB entry
    logic unused_csr_bits;
    assign unused_csr_bits = ^{csr_tlbehi[12:0], csr_tlbelo0[31:28], csr_tlbelo0[7],
                               csr_tlbelo1[31:28], csr_tlbelo1[7], csr_tlbidx[30],
                               csr_tlbidx[23:IDX_W]};

    assign cmd_accept = cmd_valid & cmd_ready;
    assign wr_fire    = wr_valid & wr_ready;

    // State register; reset leaves the controller idle and ready.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: IDLE -> WRITE -> DONE -> IDLE.
    always_comb begin
        // NOTE: a default before the case keeps this purely combinational;
        // any path that skips the assignment would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_accept) state_d = ST_WRITE;
            ST_WRITE: if (wr_fire)    state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Output decode: handshake qualifiers and the done pulse come straight
    // from the state register, so a reset during WRITE drops wr_valid at once.
    always_comb begin
        cmd_ready = 1'b0;
        wr_valid  = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE:  cmd_ready = 1'b1;
            ST_WRITE: wr_valid  = 1'b1;
            ST_DONE:  done      = 1'b1;
            default:  ;
        endcase
    end

    // Entry capture: load everything on accept, hold otherwise, so CSR
    // changes after the command are invisible to the array.
    always_comb begin
        is_fill_d = is_fill_q;
        index_d   = index_q;
        e_d       = e_q;
        vppn_d    = vppn_q;
        ps_d      = ps_q;
        g_d       = g_q;
        asid_d    = asid_q;
        ppn0_d    = ppn0_q;
        ppn1_d    = ppn1_q;
        flags0_d  = flags0_q;
        flags1_d  = flags1_q;
        if (cmd_accept) begin
            is_fill_d = cmd_is_fill;
            index_d   = cmd_is_fill ? fill_ptr_q : csr_tlbidx[IDX_W-1:0];
            // during TLB refill the written entry must exist regardless of NE
            e_d       = (csr_ecode == ECODE_TLBR) ? 1'b1 : ~csr_tlbidx[31];
            vppn_d    = csr_tlbehi[31:13];
            ps_d      = csr_tlbidx[29:24];
            g_d       = csr_tlbelo0[6] & csr_tlbelo1[6];
            asid_d    = csr_asid;
            ppn0_d    = csr_tlbelo0[27:8];
            ppn1_d    = csr_tlbelo1[27:8];
            flags0_d  = csr_tlbelo0[5:0];
            flags1_d  = csr_tlbelo1[5:0];
        end
    end

    // Entry holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_fill_q <= 1'b0;
            index_q   <= '0;
            e_q       <= 1'b0;
            vppn_q    <= '0;
            ps_q      <= '0;
            g_q       <= 1'b0;
            asid_q    <= '0;
            ppn0_q    <= '0;
            ppn1_q    <= '0;
            flags0_q  <= '0;
            flags1_q  <= '0;
        end else begin
            is_fill_q <= is_fill_d;
            index_q   <= index_d;
            e_q       <= e_d;
            vppn_q    <= vppn_d;
            ps_q      <= ps_d;
            g_q       <= g_d;
            asid_q    <= asid_d;
            ppn0_q    <= ppn0_d;
            ppn1_q    <= ppn1_d;
            flags0_q  <= flags0_d;
            flags1_q  <= flags1_d;
        end
    end

    // Fill pointer advances only when a FILL write is actually taken;
    // TLBNUM is a power of two so the increment wraps naturally.
    always_comb begin
        fill_ptr_d = fill_ptr_q;
        if (wr_fire && is_fill_q) fill_ptr_d = fill_ptr_q + IDX_W'(1);
    end

    // Fill pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fill_ptr_q <= '0;
        else        fill_ptr_q <= fill_ptr_d;
    end

    assign wr_index  = index_q;
    assign wr_e      = e_q;
    assign wr_vppn   = vppn_q;
    assign wr_ps     = ps_q;
    assign wr_g      = g_q;
    assign wr_asid   = asid_q;
    assign wr_ppn0   = ppn0_q;
    assign wr_ppn1   = ppn1_q;
    assign wr_flags0 = flags0_q;
    assign wr_flags1 = flags1_q;

endmodule

// File: tb/tb_tlb_write_ctrl.sv
// Testbench for tlb_write_ctrl: directed table, fill-pointer and stall
// sequences, reset abort, then randomized commands against an entry model.

module tb_tlb_write_ctrl;

    localparam int TLBNUM = 16;
    localparam int IDX_W  = 4;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_is_fill;
    logic [31:0]      csr_tlbehi;
    logic [31:0]      csr_tlbelo0;
    logic [31:0]      csr_tlbelo1;
    logic [31:0]      csr_tlbidx;
    logic [9:0]       csr_asid;
    logic [5:0]       csr_ecode;
    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_index;
    logic             wr_e;
    logic [18:0]      wr_vppn;
    logic [5:0]       wr_ps;
    logic             wr_g;
    logic [9:0]       wr_asid;
    logic [19:0]      wr_ppn0;
    logic [19:0]      wr_ppn1;
    logic [5:0]       wr_flags0;
    logic [5:0]       wr_flags1;
    logic             done;

    tlb_write_ctrl #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_fill(cmd_is_fill),
        .csr_tlbehi(csr_tlbehi), .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1),
        .csr_tlbidx(csr_tlbidx), .csr_asid(csr_asid), .csr_ecode(csr_ecode),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index), .wr_e(wr_e),
        .wr_vppn(wr_vppn), .wr_ps(wr_ps), .wr_g(wr_g), .wr_asid(wr_asid),
        .wr_ppn0(wr_ppn0), .wr_ppn1(wr_ppn1), .wr_flags0(wr_flags0), .wr_flags1(wr_flags1),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fill;
        logic [31:0] ehi;
        logic [31:0] elo0;
        logic [31:0] elo1;
        logic [31:0] idx;
        logic [31:0] asid;
        logic [31:0] ecode;
    } cmd_t;

    typedef struct {
        logic [31:0] index;
        logic [31:0] e;
        logic [31:0] vppn;
        logic [31:0] ps;
        logic [31:0] g;
        logic [31:0] asid;
        logic [31:0] ppn0;
        logic [31:0] ppn1;
        logic [31:0] flags0;
        logic [31:0] flags1;
    } exp_t;

    typedef struct {
        cmd_t cmd;
        int   stall;
        exp_t exp;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;
    int fill_no = 0;   // completed FILLs since last reset

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Entry as the architecture defines it, from field positions by arithmetic.
    function automatic exp_t model(input cmd_t c, input int fills_done);
        exp_t m;
        m.index  = c.fill[0] ? 32'(fills_done % TLBNUM) : c.idx % TLBNUM;
        m.e      = (c.ecode == 32'h3F) ? 32'd1 : ((c.idx / 32'h8000_0000) == 0 ? 32'd1 : 32'd0);
        m.vppn   = c.ehi / 32'd8192;
        m.ps     = (c.idx / 32'h0100_0000) % 64;
        m.g      = ((c.elo0 / 64) % 2) * ((c.elo1 / 64) % 2);
        m.asid   = c.asid % 1024;
        m.ppn0   = (c.elo0 / 256) % 32'h0010_0000;
        m.ppn1   = (c.elo1 / 256) % 32'h0010_0000;
        m.flags0 = c.elo0 % 64;
        m.flags1 = c.elo1 % 64;
        return m;
    endfunction

    task automatic check_entry(input string tag, input exp_t e);
        check({tag, ".index"},  32'(wr_index),  e.index);
        check({tag, ".e"},      32'(wr_e),      e.e);
        check({tag, ".vppn"},   32'(wr_vppn),   e.vppn);
        check({tag, ".ps"},     32'(wr_ps),     e.ps);
        check({tag, ".g"},      32'(wr_g),      e.g);
        check({tag, ".asid"},   32'(wr_asid),   e.asid);
        check({tag, ".ppn0"},   32'(wr_ppn0),   e.ppn0);
        check({tag, ".ppn1"},   32'(wr_ppn1),   e.ppn1);
        check({tag, ".flags0"}, 32'(wr_flags0), e.flags0);
        check({tag, ".flags1"}, 32'(wr_flags1), e.flags1);
    endtask

    task automatic drive_cmd(input cmd_t c);
        cmd_is_fill = c.fill[0];
        csr_tlbehi  = c.ehi;
        csr_tlbelo0 = c.elo0;
        csr_tlbelo1 = c.elo1;
        csr_tlbidx  = c.idx;
        csr_asid    = c.asid[9:0];
        csr_ecode   = c.ecode[5:0];
        cmd_valid   = 1'b1;
    endtask

    task automatic scramble_inputs();
        cmd_valid   = 1'($urandom);
        cmd_is_fill = 1'($urandom);
        csr_tlbehi  = $urandom;
        csr_tlbelo0 = $urandom;
        csr_tlbelo1 = $urandom;
        csr_tlbidx  = $urandom;
        csr_asid    = 10'($urandom);
        csr_ecode   = 6'($urandom);
    endtask

    function automatic cmd_t rand_cmd(input logic fill);
        cmd_t c;
        c.fill  = {31'd0, fill};
        c.ehi   = $urandom;
        c.elo0  = $urandom;
        c.elo1  = $urandom;
        c.idx   = $urandom;
        c.asid  = $urandom_range(0, 1023);
        c.ecode = ($urandom_range(0, 3) == 0) ? 32'h3F : $urandom_range(0, 63);
        return c;
    endfunction

    // Starts at a negedge with the controller idle; ends at the negedge
    // where it is idle again, so consecutive calls issue back-to-back.
    task automatic run_cmd(input string tag, input cmd_t c, input int stall,
                           input exp_t e, input bit scramble);
        check({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        drive_cmd(c);
        wr_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k <= stall; k++) begin
            check({tag, ".wr_valid"},      32'(wr_valid),  32'd1);
            check({tag, ".cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
            check({tag, ".done_early"},    32'(done),      32'd0);
            check_entry(tag, e);
            if (scramble) scramble_inputs();
            wr_ready = (k == stall);
            @(negedge clk);
        end
        wr_ready  = 1'b0;
        cmd_valid = 1'b0;
        check({tag, ".done"},           32'(done),      32'd1);
        check({tag, ".wr_valid_done"},  32'(wr_valid),  32'd0);
        check({tag, ".cmd_ready_done"}, 32'(cmd_ready), 32'd0);
        check_entry({tag, ".hold"}, e);
        @(negedge clk);
        check({tag, ".done_once"},      32'(done),      32'd0);
        check({tag, ".cmd_ready_back"}, 32'(cmd_ready), 32'd1);
        check({tag, ".wr_valid_idle"},  32'(wr_valid),  32'd0);
        if (c.fill[0]) fill_no++;
    endtask

    vec_t tbl[3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c;
        exp_t e;

        // directed vectors: {command, wr_ready stall cycles, expected entry}
        tbl[0] = '{cmd: '{32'd0, 32'hABCD_E000, 32'h0012_345F, 32'h0000_0143, 32'h0C00_0005, 32'h155, 32'h00},
                   stall: 0,
                   exp: '{32'd5, 32'd1, 32'h55E6F, 32'd12, 32'd1, 32'h155, 32'h01234, 32'h00001, 32'h1F, 32'h03}};
        tbl[1] = '{cmd: '{32'd0, 32'h0000_2000, 32'h0FFF_FF7F, 32'hF000_0000, 32'h8C00_0003, 32'h3FF, 32'h00},
                   stall: 2,
                   exp: '{32'd3, 32'd0, 32'h00001, 32'd12, 32'd0, 32'h3FF, 32'hFFFFF, 32'h00000, 32'h3F, 32'h00}};
        tbl[2] = '{cmd: '{32'd0, 32'h0000_2000, 32'h0FFF_FF7F, 32'hF000_0000, 32'h8C00_0003, 32'h3FF, 32'h3F},
                   stall: 1,
                   exp: '{32'd3, 32'd1, 32'h00001, 32'd12, 32'd0, 32'h3FF, 32'hFFFFF, 32'h00000, 32'h3F, 32'h00}};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_is_fill = 1'b0; wr_ready = 1'b0;
        csr_tlbehi = '0; csr_tlbelo0 = '0; csr_tlbelo1 = '0; csr_tlbidx = '0;
        csr_asid = '0; csr_ecode = '0;
        repeat (3) @(negedge clk);
        check("rst.wr_valid", 32'(wr_valid), 32'd0);
        check("rst.done",     32'(done),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst.wr_valid_rel", 32'(wr_valid), 32'd0);
        check("rst.done_rel", 32'(done), 32'd0);
        check("rst.wr_index", 32'(wr_index), 32'd0);
        check("rst.wr_e",     32'(wr_e),     32'd0);

        foreach (tbl[i]) run_cmd($sformatf("tbl%0d", i), tbl[i].cmd, tbl[i].stall, tbl[i].exp, 1'b0);

        // 17 fills wrap the pointer; a TLBWR idx=9 in the middle must not move it
        for (int i = 0; i < 17; i++) begin
            c = rand_cmd(1'b1);
            e = model(c, fill_no);
            check("fill.model_index", e.index, 32'(i % TLBNUM));
            run_cmd($sformatf("fill%0d", i), c, 0, e, 1'b0);
            if (i == 7) begin
                c = rand_cmd(1'b0);
                c.idx = (c.idx & 32'hFFFF_FFF0) | 32'd9;
                run_cmd("wr_idx9", c, 0, model(c, fill_no), 1'b0);
            end
        end

        // four-cycle wr_ready stall with CSR inputs and cmd_valid toggling meanwhile
        c = rand_cmd(1'b0);
        run_cmd("stall4", c, 4, model(c, fill_no), 1'b1);

        // reset during WRITE aborts the write and clears the fill pointer
        c = rand_cmd(1'b1);
        check("abort.cmd_ready", 32'(cmd_ready), 32'd1);
        drive_cmd(c);
        wr_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort.wr_valid_before", 32'(wr_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort.wr_valid_async", 32'(wr_valid), 32'd0);
        check("abort.done_async",     32'(done),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_no = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort.no_done", 32'(done), 32'd0);
            check("abort.idle",    32'(cmd_ready), 32'd1);
        end
        c = rand_cmd(1'b1);
        e = model(c, fill_no);
        check("abort.next_fill_index", e.index, 32'd0);
        run_cmd("post_abort_fill", c, 0, e, 1'b0);

        // random mix of commands, stalls and input noise
        for (int i = 0; i < 40; i++) begin
            c = rand_cmd(1'($urandom));
            run_cmd($sformatf("rnd%0d", i), c, $urandom_range(0, 3), model(c, fill_no), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
